pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline register that replaces fixed stage latches such as the IF/ID register. It carries a PC and an instruction between two stages using a valid/ready handshake, with a two-entry skid buffer. Stall is expressed by back-pressure and flush by a synchronous kill. It adds performance counters for stall and flush cycles, and is reused at every stage boundary of the pipelined core.

Parameters:
PC_W, 64, width of the PC field
INSTR_W, 32, width of the instruction field
NOP_INSTR, 32'h00000013, value driven on out_instr when the stage is empty (RISC-V addi x0,x0,0)
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
in_valid  in  1  upstream has a beat
in_ready  out  1  stage can accept a beat; registered, no combinational path from out_ready
in_pc  in  PC_W  upstream PC
in_instr  in  INSTR_W  upstream instruction
out_valid  out  1  stage holds a beat for downstream
out_ready  in  1  downstream accepts
out_pc  out  PC_W  head-entry PC
out_instr  out  INSTR_W  head-entry instruction
flush  in  1  kill all held beats (branch mispredict / exception)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
flush_cnt  out  CNT_W  flush cycles that discarded at least one valid beat

Behaviour:
- push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at posedge clk.
- Storage is a main register (head) plus a skid register. State is EMPTY, ONE or TWO.
- EMPTY:
  - push -> ONE, main <= in.
  - otherwise stay.
- ONE:
  - push & pop -> ONE, main <= in.
  - push only -> TWO, skid <= in.
  - pop only -> EMPTY.
  - neither -> hold.
- TWO:
  - in_ready=0, so push is impossible.
  - pop -> ONE, main <= skid.
  - else hold.
- Outputs: in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- Data path:
  - Latency is 1 cycle from push to out_valid.
  - Throughput is 1 beat/cycle when out_ready stays high.
  - Beats leave in strict FIFO order; none is dropped or duplicated.
- Empty outputs: out_pc = 0 and out_instr = NOP_INSTR whenever state = EMPTY.
- Flush:
  - When flush=1 at a posedge, next state is EMPTY and skid contents become don't-care.
  - A push in the same cycle is discarded.
  - Flush overrides push and pop; a pop in the same cycle is still counted as consumed by downstream.
  - flush_cnt increments if the state was not EMPTY.
- Reset (reset=0 at posedge):
  - state is EMPTY, in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, stall_cnt=0, flush_cnt=0.
  - Reset overrides flush and all handshakes.
  - Reset in the middle of a back-pressured transfer drops the held beats.
- Counters:
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - Counters are unaffected by flush (except flush_cnt's own increment).
- Holding: while out_valid=1 and out_ready=0, out_pc and out_instr stay stable.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - RV_NOP=32'h00000013;
  - default widths XLEN=64, ILEN=32.
- One sub-module is natural: sat_counter (parametrised width, inc, synchronous active-low clear). It is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset low 2 cycles, then high -> out_valid=0, in_ready=1, out_pc=0, out_instr=32'h00000013, both counters 0.
- Streaming: out_ready=1, in_valid=1 with pc 0x100, 0x104, 0x108 and instrs A, B, C over 3 cycles -> out shows pc 0x100, 0x104, 0x108 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure: push 0x200 then 0x204 with out_ready=0 -> state TWO, in_ready=0, out_pc holds 0x200, stall_cnt=2. Then out_ready=1 for 2 cycles -> outputs 0x200 then 0x204, then out_valid=0.
- Flush with TWO entries plus a simultaneous push of 0x300 -> next cycle out_valid=0, in_ready=1, out_instr=NOP, flush_cnt=1. Beat 0x300 never appears.
- Flush when EMPTY -> flush_cnt unchanged.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15. Reset mid-stall -> stall_cnt=0 and stored beat dropped.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared state encoding, NOP constant and default widths    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [31:0] RV_NOP = 32'h00000013;
  localparam int          XLEN   = 64;
  localparam int          ILEN   = 32;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_elastic_if : upstream/downstream handshake and flush      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int PC_W    = XLEN,
  parameter int INSTR_W = ILEN
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;

  // master drives the stage (upstream producer plus downstream ready/flush)
  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface : pipe_stage_elastic_if
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous active-low clear|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             i_clr_n,
  input  wire logic             i_inc,
  output logic      [WIDTH-1:0] o_count
);
  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != C_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_elastic : valid/ready pipeline register, 2-entry skid,    |
// | synchronous kill and saturating stall/flush counters.     Rev 1.0    |
// +----------------------------------------------------------------------+
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = XLEN,
  parameter int                 INSTR_W   = ILEN,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV_NOP),
  parameter int                 CNT_W     = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  pipe_stage_elastic_if.slave   bus,
  output logic      [CNT_W-1:0] stall_cnt,
  output logic      [CNT_W-1:0] flush_cnt
);
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic               w_stall_inc;
  logic               w_flush_inc;

  // ready decodes the state register only, so out_ready never reaches in_ready
  assign bus.in_ready  = (r_state != ST_TWO);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt  = ST_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_ld_main_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_TWO;
          w_ld_skid   = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt    = ST_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (bus.flush) begin
      w_state_nxt    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // payload registers need no reset: outputs are masked while EMPTY
  always_ff @(posedge clk) begin
    if (w_ld_main_in) begin
      r_main_pc    <= bus.in_pc;
      r_main_instr <= bus.in_instr;
    end else if (w_ld_main_skid) begin
      r_main_pc    <= r_skid_pc;
      r_main_instr <= r_skid_instr;
    end
    if (w_ld_skid) begin
      r_skid_pc    <= bus.in_pc;
      r_skid_instr <= bus.in_instr;
    end
  end

  assign bus.out_pc    = bus.out_valid ? r_main_pc    : '0;
  assign bus.out_instr = bus.out_valid ? r_main_instr : NOP_INSTR;

  assign w_stall_inc = bus.out_valid & ~bus.out_ready;
  assign w_flush_inc = bus.flush & bus.out_valid;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clr_n (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clr_n (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );
endmodule : pipe_stage_elastic
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_elastic : vector table plus FIFO-order scoreboard      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pipe_stage_elastic #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (RV_NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  typedef struct {
    logic        rst_n, iv, ordy, fl;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        e_ov, e_ir;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    int          e_st, e_fl;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } beat_t;

  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  tbl[17];
  beat_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic iv, logic [63:0] pc, logic [31:0] ins,
                              logic ordy, logic fl, logic eov, logic eir,
                              logic [63:0] epc, logic [31:0] eins, int est, int efl);
    vec_t v;
    v.rst_n = r;   v.iv = iv;     v.pc = pc;     v.ins = ins;
    v.ordy  = ordy; v.fl = fl;    v.e_ov = eov;  v.e_ir = eir;
    v.e_pc  = epc; v.e_ins = eins; v.e_st = est; v.e_fl = efl;
    return v;
  endfunction

  // inputs change 1 time unit after posedge and are stable at posedge
  task automatic drive(logic r, logic iv, logic [63:0] pc, logic [31:0] ins,
                       logic ordy, logic fl);
    reset         = r;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // negedge sees exactly the handshake the next posedge will act on
  always @(negedge clk) begin : sb_monitor
    beat_t b;
    if (reset !== 1'b1) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: popped pc %0h with nothing expected", bus.out_pc);
        end else begin
          b = sbq.pop_front();
          chk("sb_pc", bus.out_pc, b.pc);
          chk("sb_instr", 64'(bus.out_instr), 64'(b.ins));
        end
      end
      if (bus.flush) sbq.delete();
      else if (bus.in_valid && bus.in_ready) sbq.push_back('{bus.in_pc, bus.in_instr});
    end
  end

  initial begin
    logic [31:0] nop;
    int          exp_st;
    nop = RV_NOP;
    //            rst iv pc        instr          ordy fl  ov ir out_pc    out_instr     st fl
    tbl[0]  = mk(0, 0, 64'h0,   32'h0,          0, 0,   0, 1, 64'h0,   nop,          0, 0);
    tbl[1]  = mk(0, 0, 64'h0,   32'h0,          0, 0,   0, 1, 64'h0,   nop,          0, 0);
    tbl[2]  = mk(1, 1, 64'h100, 32'hAAAA0001,   1, 0,   1, 1, 64'h100, 32'hAAAA0001, 0, 0);
    tbl[3]  = mk(1, 1, 64'h104, 32'hBBBB0002,   1, 0,   1, 1, 64'h104, 32'hBBBB0002, 0, 0);
    tbl[4]  = mk(1, 1, 64'h108, 32'hCCCC0003,   1, 0,   1, 1, 64'h108, 32'hCCCC0003, 0, 0);
    tbl[5]  = mk(1, 0, 64'h0,   32'h0,          1, 0,   0, 1, 64'h0,   nop,          0, 0);
    tbl[6]  = mk(1, 1, 64'h200, 32'hDDDD0004,   0, 0,   1, 1, 64'h200, 32'hDDDD0004, 0, 0);
    tbl[7]  = mk(1, 1, 64'h204, 32'hEEEE0005,   0, 0,   1, 0, 64'h200, 32'hDDDD0004, 1, 0);
    tbl[8]  = mk(1, 0, 64'h0,   32'h0,          0, 0,   1, 0, 64'h200, 32'hDDDD0004, 2, 0);
    tbl[9]  = mk(1, 0, 64'h0,   32'h0,          1, 0,   1, 1, 64'h204, 32'hEEEE0005, 2, 0);
    tbl[10] = mk(1, 0, 64'h0,   32'h0,          1, 0,   0, 1, 64'h0,   nop,          2, 0);
    tbl[11] = mk(1, 1, 64'h208, 32'h11110006,   0, 0,   1, 1, 64'h208, 32'h11110006, 2, 0);
    tbl[12] = mk(1, 1, 64'h20C, 32'h22220007,   0, 0,   1, 0, 64'h208, 32'h11110006, 3, 0);
    tbl[13] = mk(1, 1, 64'h300, 32'h33330008,   0, 1,   0, 1, 64'h0,   nop,          4, 1);
    tbl[14] = mk(1, 1, 64'h304, 32'h44440009,   1, 1,   0, 1, 64'h0,   nop,          4, 1);
    tbl[15] = mk(1, 1, 64'h308, 32'h5555000A,   1, 0,   1, 1, 64'h308, 32'h5555000A, 4, 1);
    tbl[16] = mk(1, 0, 64'h0,   32'h0,          1, 1,   0, 1, 64'h0,   nop,          4, 2);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst_n, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d_in_ready", i),  64'(bus.in_ready),  64'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_pc", i),    bus.out_pc,         tbl[i].e_pc);
      chk($sformatf("v%0d_out_instr", i), 64'(bus.out_instr), 64'(tbl[i].e_ins));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt),     64'(tbl[i].e_st));
      chk($sformatf("v%0d_flush_cnt", i), 64'(flush_cnt),     64'(tbl[i].e_fl));
    end

    // long back-pressure: counter must stop at 15 while the head stays put
    drive(1, 1, 64'h400, 32'h6666000B, 0, 0);
    chk("sat_load_pc", bus.out_pc, 64'h400);
    for (int k = 1; k <= 20; k++) begin
      drive(1, 0, 64'h0, 32'h0, 0, 0);
      exp_st = (4 + k > 15) ? 15 : 4 + k;
      chk($sformatf("sat%0d_stall_cnt", k), 64'(stall_cnt), 64'(exp_st));
      chk($sformatf("sat%0d_hold_pc", k), bus.out_pc, 64'h400);
      chk($sformatf("sat%0d_hold_instr", k), 64'(bus.out_instr), 64'h6666000B);
    end

    // reset in the middle of the stall drops the held beat and clears counters
    drive(0, 1, 64'h500, 32'h7777000C, 0, 1);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mid_pc", bus.out_pc, 64'h0);
    chk("rst_mid_instr", 64'(bus.out_instr), 64'(nop));
    chk("rst_mid_stall", 64'(stall_cnt), 64'd0);
    chk("rst_mid_flush", 64'(flush_cnt), 64'd0);
    drive(1, 0, 64'h0, 32'h0, 1, 0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_stall", 64'(stall_cnt), 64'd0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule : tb_pipe_stage_elastic
`default_nettype wire
